// File: rtl/numlength_bcd_seq.sv
// Sequential signed-binary to BCD converter (double dabble, one bit per clock) with digit count
// and overflow. Define NUMLEN_LEADING_BLANK_EN to drive digits above the length with blank code F.
module numlength_bcd_seq #(
    parameter int unsigned WIDTH      = 22,
    parameter int unsigned MAX_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        binary_num,
    output logic                    ready,
    output logic                    done,
    output logic                    negative,
    output logic [4*MAX_DIGITS-1:0] bcd,
    output logic [3:0]              length,
    output logic                    overflow
);

    localparam int unsigned BW = 4 * MAX_DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MAX_MAG = pow10(MAX_DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StFin
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] mag_q;
    logic [BW-1:0]   work_q;
    logic            neg_work_q;
    logic            ovf_work_q;

    logic [WIDTH-1:0] mag_in;
    logic             ovf_in;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_next;
    logic [WIDTH-1:0] mag_next;
    logic [3:0]       len_c;
    logic [3:0]       len_fin;
    logic [BW-1:0]    bcd_base;
    logic [BW-1:0]    bcd_fin;

    // Negating in WIDTH bits maps the most negative value to 2^(WIDTH-1) as unsigned.
    always_comb begin
        mag_in = binary_num[WIDTH-1] ? (~binary_num + 1'b1) : binary_num;
        ovf_in = 64'(mag_in) > MAX_MAG;
    end

    always_comb begin
        adj = work_q;
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        // Bits leaving the top digit are dropped; the overflow compare already covers them.
        work_next = {adj[BW-2:0], mag_q[WIDTH-1]};
        mag_next  = {mag_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        len_c = 4'd1;
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
            if (work_q[4*i +: 4] != 4'd0) begin
                len_c = 4'(i + 1);
            end
        end
        len_fin = ovf_work_q ? 4'(MAX_DIGITS) : len_c;
        bcd_base = work_q;
        if (ovf_work_q) begin
            for (int i = 0; i < int'(MAX_DIGITS); i++) begin
                bcd_base[4*i +: 4] = 4'd9;
            end
        end
`ifdef NUMLEN_LEADING_BLANK_EN
        bcd_fin = bcd_base;
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
            if (i >= int'(len_fin)) begin
                bcd_fin[4*i +: 4] = 4'hF;
            end
        end
`else
        bcd_fin = bcd_base;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mag_q      <= '0;
            work_q     <= '0;
            neg_work_q <= 1'b0;
            ovf_work_q <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            negative   <= 1'b0;
            bcd        <= '0;
            length     <= 4'd1;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mag_q      <= mag_in;
                        work_q     <= '0;
                        neg_work_q <= binary_num[WIDTH-1];
                        ovf_work_q <= ovf_in;
                        cnt_q      <= '0;
                        ready      <= 1'b0;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    work_q <= work_next;
                    mag_q  <= mag_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    bcd      <= bcd_fin;
                    length   <= len_fin;
                    overflow <= ovf_work_q;
                    negative <= neg_work_q;
                    done     <= 1'b1;
                    ready    <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_numlength_bcd_seq.sv
// Directed bench for numlength_bcd_seq: default instance (22 bits, 6 digits) and a small
// instance (8 bits, 3 digits), checked against an arithmetic reference through a scoreboard.
module tb_numlength_bcd_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [21:0] binary_num;
    logic        ready, done, negative, overflow;
    logic [23:0] bcd;
    logic [3:0]  length;

    logic        s_start;
    logic [7:0]  s_num;
    logic        s_ready, s_done, s_negative, s_overflow;
    logic [11:0] s_bcd;
    logic [3:0]  s_length;

    int compared = 0;
    int mism     = 0;

    typedef struct {
        logic        neg;
        logic [35:0] bcd;
        logic [3:0]  len;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    numlength_bcd_seq #(.WIDTH(22), .MAX_DIGITS(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .binary_num (binary_num),
        .ready      (ready),
        .done       (done),
        .negative   (negative),
        .bcd        (bcd),
        .length     (length),
        .overflow   (overflow)
    );

    numlength_bcd_seq #(.WIDTH(8), .MAX_DIGITS(3)) dut_small (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (s_start),
        .binary_num (s_num),
        .ready      (s_ready),
        .done       (s_done),
        .negative   (s_negative),
        .bcd        (s_bcd),
        .length     (s_length),
        .overflow   (s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference built from repeated division, independent of the shift-and-add method.
    function automatic exp_t model(input longint v, input int d);
        exp_t   e;
        longint mag;
        longint lim;
        longint tmp;
        logic [3:0] dig;
        mag = (v < 0) ? -v : v;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        lim = lim - 1;
        e.neg = (v < 0);
        e.bcd = '0;
        e.len = 4'd1;
        e.ovf = 1'b0;
        if (mag > lim) begin
            e.ovf = 1'b1;
            e.len = 4'(d);
            for (int i = 0; i < d; i++) e.bcd[4*i +: 4] = 4'd9;
        end else begin
            tmp = mag;
            for (int i = 0; i < d; i++) begin
                dig = 4'(tmp % 10);
                e.bcd[4*i +: 4] = dig;
                if (dig != 4'd0) e.len = 4'(i + 1);
                tmp = tmp / 10;
            end
        end
`ifdef NUMLEN_LEADING_BLANK_EN
        for (int i = 0; i < d; i++) begin
            if (i >= int'(e.len)) e.bcd[4*i +: 4] = 4'hF;
        end
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        assert (got === want)
        else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input int sel, input logic st, input longint v);
        if (sel == 0) begin
            start      = st;
            binary_num = 22'(v);
        end else begin
            s_start = st;
            s_num   = 8'(v);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done : s_done;
    endfunction

    // Waits for done (sampled on negedges), then pops and compares the oldest expectation.
    task automatic wait_done(input int sel, input int budget, input int glitch, input longint other,
                             output int lat);
        exp_t e;
        lat = 0;
        while (!get_done(sel) && lat < budget) begin
            @(negedge clk);
            lat++;
            if (lat == glitch) drive(sel, 1'b1, other);
            else if (lat == glitch + 1) drive(sel, 1'b0, other);
        end
        check("done_seen", 64'(get_done(sel)), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (get_done(sel)) begin
                if (sel == 0) begin
                    check("negative", 64'(negative), 64'(e.neg));
                    check("bcd", 64'(bcd), 64'(e.bcd));
                    check("length", 64'(length), 64'(e.len));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    check("ready_in_done", 64'(ready), 64'd1);
                end else begin
                    check("s_negative", 64'(s_negative), 64'(e.neg));
                    check("s_bcd", 64'(s_bcd), 64'(e.bcd));
                    check("s_length", 64'(s_length), 64'(e.len));
                    check("s_overflow", 64'(s_overflow), 64'(e.ovf));
                    check("s_ready_in_done", 64'(s_ready), 64'd1);
                end
            end
        end
    endtask

    task automatic send(input int sel, input longint v, input int glitch, input longint other,
                        input int exp_lat);
        int lat;
        @(negedge clk);
        check("ready_before_start", 64'((sel == 0) ? ready : s_ready), 64'd1);
        drive(sel, 1'b1, v);
        sb.push_back(model(v, (sel == 0) ? 6 : 3));
        @(negedge clk);
        drive(sel, 1'b0, v);
        wait_done(sel, exp_lat + 10, glitch, other, lat);
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_negative"}, 64'(negative), 64'd0);
        check({tag, "_bcd"}, 64'(bcd), 64'd0);
        check({tag, "_length"}, 64'(length), 64'd1);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int  lat;
        logic seen;
        reset_n    = 1'b0;
        start      = 1'b0;
        binary_num = '0;
        s_start    = 1'b0;
        s_num      = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        send(0, 0, -1, 0, 23);
        send(0, -12345, -1, 0, 23);
        send(0, 999999, -1, 0, 23);
        send(0, 1000000, -1, 0, 23);
        send(0, -2097152, -1, 0, 23);
        send(0, 42, -1, 0, 23);

        // Start pulsed mid-conversion with another value must be ignored, not queued.
        send(0, 31415, 5, -777, 23);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_queued_start", 64'(seen), 64'd0);

        // Start held high through done chains the next conversion.
        @(negedge clk);
        check("ready_before_chain", 64'(ready), 64'd1);
        drive(0, 1'b1, 271828);
        sb.push_back(model(271828, 6));
        @(negedge clk);
        wait_done(0, 40, -1, 0, lat);
        check("chain_first_latency", 64'(lat), 64'd23);
        drive(0, 1'b1, -54321);
        sb.push_back(model(-54321, 6));
        @(negedge clk);
        drive(0, 1'b0, -54321);
        wait_done(0, 40, -1, 0, lat);
        check("chain_spacing", 64'(lat), 64'd23);

        // Reset at cycle 10 of a conversion aborts it without a done pulse.
        @(negedge clk);
        drive(0, 1'b1, 777);
        @(negedge clk);
        drive(0, 1'b0, 777);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_done_after_abort", 64'(seen), 64'd0);
        check_reset_values("post_abort");
        send(0, 9, -1, 0, 23);

        send(1, -128, -1, 0, 9);
        send(1, 127, -1, 0, 9);
        send(1, 0, -1, 0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
